// File: rtl/alu_pipe_n.sv
// alu_pipe_n: single-issue ALU with a valid/ready request port, a registered
// result port and a stored carry for multi-word arithmetic.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only while idle)
//   a, b                  operands (WIDTH bits)
//   sel                   opcode: 000 A+cin, 001 A+B+cin, 010 A+~B+cin,
//                         011 A+all-ones+cin, 100 A&B, 101 A|B, 110 A^B, 111 ~A
//   cin, chain            carry-in; chain=1 uses the stored carry instead
//   out_valid / out_ready result handshake
//   f                     registered result
//   cout, zero, neg, ovf  registered flags
module alu_pipe_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             cin,
    input  logic             chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t state, state_nx;

    // Operands captured at accept; the effective carry-in is resolved then.
    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       sel_r;
    logic             cin_r;
    logic             carry_reg;

    logic             accept, done;
    logic [WIDTH-1:0] bop, f_nx;
    logic [WIDTH:0]   sum;
    logic             cout_nx, ovf_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: state_nx = HOLD;
            HOLD: begin
                if (out_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bop     = '0;
        sum     = '0;
        f_nx    = '0;
        cout_nx = 1'b0;
        ovf_nx  = 1'b0;
        case (sel_r[1:0])
            2'b00:   bop = '0;
            2'b01:   bop = b_r;
            2'b10:   bop = ~b_r;
            default: bop = '1;
        endcase
        sum = {1'b0, a_r} + {1'b0, bop} + {{WIDTH{1'b0}}, cin_r};
        if (!sel_r[2]) begin
            f_nx    = sum[WIDTH-1:0];
            cout_nx = sum[WIDTH];
            ovf_nx  = (a_r[WIDTH-1] == bop[WIDTH-1]) && (f_nx[WIDTH-1] != a_r[WIDTH-1]);
        end else begin
            case (sel_r[1:0])
                2'b00:   f_nx = a_r & b_r;
                2'b01:   f_nx = a_r | b_r;
                2'b10:   f_nx = a_r ^ b_r;
                default: f_nx = ~a_r;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            sel_r     <= '0;
            cin_r     <= 1'b0;
            carry_reg <= 1'b0;
            out_valid <= 1'b0;
            f         <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                sel_r <= sel;
                cin_r <= chain ? carry_reg : cin;
            end
            if (state == EXEC) begin
                f         <= f_nx;
                cout      <= cout_nx;
                ovf       <= ovf_nx;
                zero      <= (f_nx == '0);
                neg       <= f_nx[WIDTH-1];
                out_valid <= 1'b1;
                // Logic ops leave the chained carry untouched.
                if (!sel_r[2]) carry_reg <= cout_nx;
            end
            if (done) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_n.sv
// tb_alu_pipe_n: directed self-checking bench for alu_pipe_n (WIDTH=8).
module tb_alu_pipe_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] sel = '0;
    logic       cin = 1'b0;
    logic       chain = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] f;
    logic       cout, zero, neg, ovf;

    int total = 0;
    int bad = 0;
    int lat;

    alu_pipe_n #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .cin(cin), .chain(chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Issue one request and wait for out_valid; lat = edges from accept
    // (accept edge counted as 1) to out_valid, or -1 on timeout.
    // Inputs are scrambled right after accept.
    task automatic run_op(input logic [2:0] s, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic ch);
        logic rdy;
        logic acc;
        int   n;
        @(negedge clk);
        in_valid = 1'b1; sel = s; a = av; b = bv; cin = ci; chain = ch;
        acc = 1'b0; n = 0;
        while (!acc && n < 10) begin
            rdy = in_ready;
            @(posedge clk);
            acc = rdy;
            n++;
        end
        #1;
        in_valid = 1'b0; a = 8'hC3; b = 8'h99; sel = 3'b110; cin = ~ci; chain = ~ch;
        lat = -1;
        if (acc) begin
            n = 1;
            while (!out_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            if (out_valid) lat = n;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (f !== 8'h00) begin bad++; $display("FAIL rst_f got=%h want=%h", f, 8'h00); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if ({cout, zero, neg, ovf} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b want=0000", {cout, zero, neg, ovf}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_add();
        run_op(3'b001, 8'hFF, 8'h01, 1'b0, 1'b0);
        total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d want=2", lat); end
        total++; if (f !== 8'h00) begin bad++; $display("FAIL add_f got=%h want=00", f); end
        total++; if ({cout, zero, neg, ovf} !== 4'b1100) begin bad++; $display("FAIL add_flags got=%b want=1100", {cout, zero, neg, ovf}); end
        finish_op();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_release got=%b want=0", out_valid); end
        run_op(3'b000, 8'h7F, 8'h00, 1'b1, 1'b0);
        total++; if (f !== 8'h80) begin bad++; $display("FAIL inc_f got=%h want=80", f); end
        total++; if ({cout, zero, neg, ovf} !== 4'b0011) begin bad++; $display("FAIL inc_flags got=%b want=0011", {cout, zero, neg, ovf}); end
        finish_op();
    endtask

    task automatic test_sub();
        run_op(3'b010, 8'h80, 8'h01, 1'b1, 1'b0);
        total++; if (f !== 8'h7F) begin bad++; $display("FAIL sub_f got=%h want=7f", f); end
        total++; if ({cout, zero, neg, ovf} !== 4'b1001) begin bad++; $display("FAIL sub_flags got=%b want=1001", {cout, zero, neg, ovf}); end
        finish_op();
        run_op(3'b011, 8'h00, 8'h55, 1'b0, 1'b0);
        total++; if (f !== 8'hFF) begin bad++; $display("FAIL dec_f got=%h want=ff", f); end
        total++; if ({cout, zero, neg, ovf} !== 4'b0010) begin bad++; $display("FAIL dec_flags got=%b want=0010", {cout, zero, neg, ovf}); end
        finish_op();
    endtask

    task automatic test_chain();
        run_op(3'b001, 8'hFF, 8'h01, 1'b0, 1'b0);
        total++; if ({f, cout} !== {8'h00, 1'b1}) begin bad++; $display("FAIL chain_lo got=%h/%b want=00/1", f, cout); end
        finish_op();
        run_op(3'b100, 8'h0F, 8'hF0, 1'b0, 1'b0);
        total++; if ({f, cout, zero} !== {8'h00, 1'b0, 1'b1}) begin bad++; $display("FAIL chain_and got=%h/%b%b want=00/01", f, cout, zero); end
        finish_op();
        run_op(3'b001, 8'h01, 8'h00, 1'b0, 1'b1);
        total++; if ({f, cout} !== {8'h02, 1'b0}) begin bad++; $display("FAIL chain_hi got=%h/%b want=02/0", f, cout); end
        finish_op();
    endtask

    task automatic test_logic();
        run_op(3'b001, 8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op();
        run_op(3'b111, 8'h5A, 8'h00, 1'b1, 1'b0);
        total++; if (f !== 8'hA5) begin bad++; $display("FAIL not_f got=%h want=a5", f); end
        total++; if ({cout, zero, neg, ovf} !== 4'b0010) begin bad++; $display("FAIL not_flags got=%b want=0010", {cout, zero, neg, ovf}); end
        finish_op();
        run_op(3'b110, 8'h3C, 8'h3C, 1'b0, 1'b0);
        total++; if ({f, zero} !== {8'h00, 1'b1}) begin bad++; $display("FAIL xor got=%h/%b want=00/1", f, zero); end
        finish_op();
        run_op(3'b101, 8'h0F, 8'h30, 1'b0, 1'b0);
        total++; if ({f, zero, neg} !== {8'h3F, 2'b00}) begin bad++; $display("FAIL or got=%h/%b%b want=3f/00", f, zero, neg); end
        finish_op();
    endtask

    task automatic test_backpressure();
        run_op(3'b001, 8'h12, 8'h34, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; sel = 3'b001; a = 8'h77; b = 8'h11;
            @(posedge clk); #1;
            total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_hs[%0d] got=%b want=10", i, {out_valid, in_ready}); end
            total++; if ({f, cout, zero, neg, ovf} !== {8'h46, 4'b0000}) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b want=46/0000", i, f, {cout, zero, neg, ovf}); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_done got=%b want=01", {out_valid, in_ready}); end
        @(posedge clk); #1;
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_idle got=%b want=01", {out_valid, in_ready}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1;
        run_op(3'b001, 8'h20, 8'h22, 1'b1, 1'b0);
        total++; if ({lat, f} !== {32'd2, 8'h43}) begin bad++; $display("FAIL b2b_first got=%0d/%h want=2/43", lat, f); end
        @(posedge clk); #1;
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL b2b_ack got=%b want=01", {out_valid, in_ready}); end
        run_op(3'b010, 8'h05, 8'h03, 1'b1, 1'b0);
        total++; if ({lat, f, cout} !== {32'd2, 8'h02, 1'b1}) begin bad++; $display("FAIL b2b_second got=%0d/%h/%b want=2/02/1", lat, f, cout); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_ack2 got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        run_op(3'b001, 8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op();
        @(negedge clk);
        in_valid = 1'b1; sel = 3'b001; a = 8'h10; b = 8'h20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if ({out_valid, f, cout, zero, neg, ovf} !== 13'h0) begin bad++; $display("FAIL rmid_clear got=%b/%h/%b want=0/00/0000", out_valid, f, {cout, zero, neg, ovf}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL rmid_ready got=%b want=01", {out_valid, in_ready}); end
        run_op(3'b001, 8'h01, 8'h01, 1'b1, 1'b1);
        total++; if ({lat, f, cout} !== {32'd2, 8'h02, 1'b0}) begin bad++; $display("FAIL rmid_chain got=%0d/%h/%b want=2/02/0", lat, f, cout); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_chain();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_pipe_n.md
ALU_PIPE_N -- requirements
Module: alu_pipe_n

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal values 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: sel  input  3  opcode: 000 A+cin, 001 A+B+cin, 010 A+~B+cin, 011 A+all-ones+cin, 100 A&B, 101 A|B, 110 A^B, 111 ~A.
REQ-009 SHALL have port: cin  input  1  carry-in for arithmetic ops.
REQ-010 SHALL have port: chain  input  1  when 1, use the stored carry instead of cin (multi-word arithmetic).
REQ-011 SHALL have port: out_valid  output  1  result valid.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port: f  output  WIDTH  registered result.
REQ-014 SHALL have port: cout, zero, neg, ovf  output  1 each  registered carry, result==0, f[WIDTH-1], signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid & in_ready, which captures a, b, sel, cin and chain into internal registers and moves to EXEC.
REQ-017 In EXEC, the block SHALL compute from the captured values, register f and the flags, set out_valid and move to HOLD (accept-to-out_valid latency exactly 2 cycles).
REQ-018 In HOLD, f, the flags and out_valid SHALL stay stable until out_valid & out_ready; at that edge out_valid SHALL go 0 and the FSM SHALL return to IDLE; if out_ready is already 1 on entry, the handshake completes on the first HOLD cycle.
REQ-019 The block SHALL NOT accept a new request in the cycle the result handshake completes; one op is in flight at most; throughput is at most 1 op per 3 cycles.
REQ-020 Effective carry-in SHALL be: chain ? carry_reg : cin, sampled at accept.
REQ-021 Arithmetic ops (sel[2]=0) SHALL form Bop = 0, b, ~b or all-ones for sel 000..011, compute the (WIDTH+1)-bit sum a+Bop+cin_eff, and set f = sum[WIDTH-1:0] and cout = sum[WIDTH].
REQ-022 For arithmetic ops, ovf SHALL be (a[msb]==Bop[msb]) & (f[msb]!=a[msb]).
REQ-023 Logic ops (sel[2]=1) SHALL produce the bitwise result with cout=0 and ovf=0.
REQ-024 zero and neg SHALL be derived from f for every op.
REQ-025 carry_reg SHALL load cout at the EXEC edge of arithmetic ops only; logic ops SHALL leave it unchanged.
REQ-026 Changes on the inputs outside the accept cycle SHALL NOT affect the in-flight result.

Reset
REQ-027 On rst=1, the block SHALL immediately (asynchronously) set state=IDLE, out_valid=0, f=0, cout=0, zero=0, neg=0, ovf=0, carry_reg=0 and clear the captured operand registers.
REQ-028 A reset during EXEC or HOLD SHALL discard the in-flight op; in_ready SHALL be 1 on the first clock edge after rst deasserts.

Verification
REQ-029 WIDTH=8, sel=001, a=FF, b=01, cin=0 -> f=00, cout=1, zero=1, ovf=0; out_valid asserts 2 cycles after accept.
REQ-030 sel=010, a=80, b=01, cin=1 -> f=7F, cout=1, ovf=1, neg=0; sel=011, a=00, cin=0 -> f=FF, cout=0, neg=1.
REQ-031 16-bit add 01FF+0001: beat 1 sel=001, a=FF, b=01, cin=0 -> f=00, cout=1; then sel=100, a=0F, b=F0 -> f=00, carry_reg still 1; beat 2 sel=001, a=01, b=00, chain=1 -> f=02, cout=0.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> f and flags stable, in_ready=0, and a concurrent in_valid is not accepted; out_ready=1 -> one handshake, then IDLE.
REQ-033 Assert rst mid-EXEC after an op that left carry_reg=1 -> all outputs 0 without a clock edge; after release, in_ready=1 and sel=001, a=01, b=01, chain=1 -> f=02.
REQ-034 sel=111, a=5A -> f=A5, cout=0, ovf=0, neg=1; sel=110, a=b=3C -> f=00, zero=1.
